div_seq: RTL and testbench
==========================

# div_seq

Sequential signed 32-bit divider in the multicycle datapath's HI/LO stage. It takes operands from the ALU source muxes and produces remainder (hi) and quotient (lo) for the HI/LO select muxes. It handshakes with the control unit through a start pulse and a done pulse. A zero divisor raises the division exception flag consumed by the control unit.

## Interface
- WIDTH, 32, operand and result width; 32 is the only supported value.

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request pulse from control unit, sampled on rising edge
- a  input  WIDTH  dividend (signed, two's complement), sampled with start
- b  input  WIDTH  divisor (signed, two's complement), sampled with start
- hi  output  WIDTH  remainder of last completed division
- lo  output  WIDTH  quotient of last completed division
- busy  output  1  division in progress
- done  output  1  one-cycle pulse: hi/lo just updated
- div_zero  output  1  one-cycle pulse: start seen with b == 0

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: 32 iterations of a restoring shift/subtract on magnitudes.
  - FIX: apply signs, write hi/lo.
- IDLE, start=1, b != 0:
  - Latch |a| and |b|, sign_q = a[31]^b[31], sign_r = a[31].
  - Clear the 32-bit partial remainder, clear the 6-bit counter, go to CALC.
- IDLE, start=1, b == 0:
  - Stay in IDLE and pulse div_zero.
  - hi/lo are unchanged, busy stays 0, no done.
- CALC, each cycle:
  - Shift {rem, quot} left 1.
  - Subtract the divisor magnitude from rem using a 33-bit trial. If the result is non-negative, keep it and set quot[0]=1.
  - Increment the counter. After the 32nd iteration go to FIX.
- FIX:
  - lo = sign_q ? -quot : quot.
  - hi = sign_r ? -rem : rem.
  - Pulse done and return to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000 is exact.
  - Negation wraps modulo 2^32. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no exception.
- start while busy (CALC or FIX) is ignored. Operands are not re-sampled.
- hi/lo change only in FIX. They hold their values across IDLE, across ignored starts, and across div_zero events.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_zero=0. All internal operand registers clear.
- Reset asserted mid-CALC aborts the operation immediately.
  - No done is produced.
  - The first start after reset is released is handled normally.
- Let T0 be the edge that samples start=1 with b != 0:
  - T1..T32: iterations.
  - T33: FIX updates hi/lo and sets done=1; busy falls to 0.
  - T34: done=0.
  - busy is 1 from T0 to T33, i.e. 33 cycles.
  - done is high for exactly the cycle between T33 and T34.
- A start sampled at T34 begins a new division; back-to-back throughput is one division per 34 cycles.
- Divide by zero: div_zero is 1 from T0 to T1 (registered, one cycle). The control unit samples it the cycle after asserting start.
- done and div_zero are never high in the same cycle.
- busy and done are never high in the same cycle.

## Test plan
- After reset release, drive a=7, b=2, start one cycle. Required:
  - busy high for 33 cycles.
  - done high 33 edges after the start edge.
  - lo=0x00000003, hi=0x00000001.
- Sign cases, one run each:
  - a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=7, b=-2: lo=0xFFFFFFFD, hi=0x00000001.
  - a=-7, b=-2: lo=0x00000003, hi=0xFFFFFFFF.
- Divide by zero: hold hi/lo from a prior result, then drive a=5, b=0 with start. Required:
  - div_zero high exactly one cycle.
  - busy=0, no done, hi/lo unchanged.
- Overflow case: a=0x80000000, b=0xFFFFFFFF. Required: lo=0x80000000, hi=0, div_zero never asserted.
- Start a=100, b=7, then pulse start again at T5 with a=1, b=1. Required: the second start is ignored, and the single done at T33 gives lo=14, hi=2.
- Start a=100, b=7, then pull reset low at T10 for 2 cycles. Required:
  - All outputs 0, no done.
  - A subsequent start with a=9, b=3 yields lo=3, hi=0 at the normal latency.

Source files
------------

// File: rtl/div_seq.sv
// Sequential signed 32-bit divider: 32-cycle restoring shift/subtract on magnitudes,
// with a sign-fixup cycle that writes remainder to hi and quotient to lo.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             sign_q;
    logic             sign_r;
    logic [5:0]       cnt;
    logic [WIDTH:0]   trial;
    logic             load;
    logic             step;
    logic             finish;
    logic             zero_hit;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is exact when read back as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        zero_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        zero_hit = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == 6'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Shifted remainder carries the next dividend bit; the 33rd bit of the
    // difference is the borrow that decides restore vs. keep.
    assign trial = {rem, quot[WIDTH-1]} - {1'b0, dvs};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvs      <= '0;
            quot     <= '0;
            rem      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= finish;
            div_zero <= zero_hit;
            if (load) begin
                quot   <= magnitude(a);
                dvs    <= magnitude(b);
                sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                sign_r <= a[WIDTH-1];
                rem    <= '0;
                cnt    <= '0;
            end
            if (step) begin
                if (!trial[WIDTH]) begin
                    rem  <= trial[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], 1'b1};
                end else begin
                    rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
                    quot <= {quot[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt + 6'd1;
            end
            if (finish) begin
                lo <= apply_sign(quot, sign_q);
                hi <= apply_sign(rem, sign_r);
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed sign/boundary cases plus random operands checked
// against 64-bit integer division.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_fails  = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Quotient truncates toward zero, remainder follows the dividend; results wrap to 32 bits.
    task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] q, output logic [31:0] r);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q = 32'(sx / sy);
        r = 32'(sx % sy);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one division; if ign_at > 0 a second start (a=1,b=1) is sampled at edge T<ign_at>.
    task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y, input int ign_at);
        logic [31:0] q;
        logic [31:0] r;
        int done_at;
        int busy_cnt;
        int dz_seen;
        ref_div(x, y, q, r);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        dz_seen  = div_zero ? 1 : 0;
        done_at  = -1;
        for (int k = 1; k <= 40; k++) begin
            if (ign_at > 0 && k == ign_at) begin
                a = 32'd1;
                b = 32'd1;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (div_zero) dz_seen++;
            if (done) begin
                done_at = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, " done latency"}, 32'(done_at), 32'd33);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd33);
        check({tag, " busy with done"}, {31'd0, busy}, 32'd0);
        check({tag, " div_zero"}, 32'(dz_seen), 32'd0);
        check({tag, " lo"}, lo, q);
        check({tag, " hi"}, hi, r);
        tick();
        check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_zero(input string tag, input logic [31:0] x);
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        hold_hi = hi;
        hold_lo = lo;
        a = x;
        b = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " div_zero set"}, {31'd0, div_zero}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        tick();
        check({tag, " div_zero clear"}, {31'd0, div_zero}, 32'd0);
        check({tag, " done later"}, {31'd0, done}, 32'd0);
        check({tag, " hi held"}, hi, hold_hi);
        check({tag, " lo held"}, lo, hold_lo);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset flags", {29'd0, busy, done, div_zero}, 32'd0);
        reset = 1'b1;
        tick();

        run_div("7/2", 32'd7, 32'd2, 0);
        check("7/2 lo const", lo, 32'h0000_0003);
        check("7/2 hi const", hi, 32'h0000_0001);
        run_div("-7/2", 32'hFFFF_FFF9, 32'd2, 0);
        check("-7/2 lo const", lo, 32'hFFFF_FFFD);
        check("-7/2 hi const", hi, 32'hFFFF_FFFF);
        run_div("7/-2", 32'd7, 32'hFFFF_FFFE, 0);
        check("7/-2 lo const", lo, 32'hFFFF_FFFD);
        check("7/-2 hi const", hi, 32'h0000_0001);
        run_div("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
        check("-7/-2 lo const", lo, 32'h0000_0003);
        check("-7/-2 hi const", hi, 32'hFFFF_FFFF);

        run_zero("5/0", 32'd5);

        run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("min/-1 lo const", lo, 32'h8000_0000);
        check("min/-1 hi const", hi, 32'h0000_0000);

        run_div("ignored start", 32'd100, 32'd7, 5);
        check("ignored lo const", lo, 32'd14);
        check("ignored hi const", hi, 32'd2);

        // Reset asserted at T10 of an in-flight division.
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort flags", {29'd0, busy, done, div_zero}, 32'd0);
        tick();
        tick();
        check("abort no done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        tick();
        run_div("9/3 after reset", 32'd9, 32'd3, 0);
        check("9/3 lo const", lo, 32'd3);
        check("9/3 hi const", hi, 32'd0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(1, 9));
                1: rb = -32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                3: rb = 32'h8000_0000;
                default: ;
            endcase
            if (i % 8 == 7) begin
                run_zero("rand zero", ra);
            end else begin
                if (rb == 32'd0) rb = 32'd3;
                run_div("rand", ra, rb, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
